change_return_controller: RTL and testbench

- Sequences the coin-return ejectors of the vending machine.
- The vending FSM hands over a change or refund amount through a valid/ready handshake. This block pays it out as timed one-hot ejector pulses (50c, 20c, 10c) from three finite coin tubes, then reports done and any shortfall.
- Sits between the vending_machine money path and the physical ejector solenoids. It owns the tube inventory counters.

---
 rtl/vending_pkg.sv | 28 ++
 rtl/coin_tube_counter.sv | 39 +++
 rtl/change_return_controller.sv | 175 +++++++++++++++++
 tb/tb_change_return_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared vending-machine constants: coin values, coin-select encoding and payout FSM states.
package vending_pkg;

    // Coin values in 10c units
    localparam logic [4:0] COIN_10 = 5'd1;
    localparam logic [4:0] COIN_20 = 5'd2;
    localparam logic [4:0] COIN_50 = 5'd5;

    // Coin-select encoding, shared with the vending_machine coin input
    localparam logic [1:0] SEL_10 = 2'b00;
    localparam logic [1:0] SEL_20 = 2'b01;
    localparam logic [1:0] SEL_50 = 2'b10;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] PULSE  = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StSelect = SELECT,
        StPulse  = PULSE,
        StGap    = GAP,
        StDone   = DONE
    } state_e;

endpackage

// File: rtl/coin_tube_counter.sv
// 4-bit saturating coin inventory counter with one-coin refill and dispense per cycle.
module coin_tube_counter #(
    parameter int unsigned TubeMax  = 15,
    parameter int unsigned TubeInit = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] cnt_o
);

    localparam logic [3:0] MaxVal  = 4'(TubeMax);
    localparam logic [3:0] InitVal = 4'(TubeInit);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A refill and a dispense in the same cycle cancel out
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q < MaxVal)) begin
            cnt_d = cnt_q + 4'd1;
        end else if (dec_i && !inc_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= InitVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/change_return_controller.sv
// Pays out a change amount as timed one-hot ejector pulses, greedily from 50c/20c/10c tubes.
module change_return_controller
    import vending_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 3,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned TUBE_MAX     = 15,
    parameter int unsigned TUBE_INIT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [4:0] req_amount,
    output logic       req_ready,
    output logic       eject_10,
    output logic       eject_20,
    output logic       eject_50,
    output logic       busy,
    output logic       done,
    output logic [4:0] shortfall,
    input  logic       refill_10,
    input  logic       refill_20,
    input  logic       refill_50,
    output logic [3:0] cnt_10,
    output logic [3:0] cnt_20,
    output logic [3:0] cnt_50
);

    localparam logic [3:0] PulseLoad = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GapLoad   = 4'(GAP_CYCLES - 1);

    state_e     state_q;
    logic [4:0] remaining_q;
    logic [3:0] timer_q;

    logic       pick;
    logic [1:0] pick_sel;
    logic [4:0] pick_val;
    logic       dec_10;
    logic       dec_20;
    logic       dec_50;

    // Greedy coin choice from the live tube counts
    always_comb begin
        pick     = 1'b0;
        pick_sel = SEL_10;
        pick_val = 5'd0;
        if ((remaining_q >= COIN_50) && (cnt_50 != 4'd0)) begin
            pick     = 1'b1;
            pick_sel = SEL_50;
            pick_val = COIN_50;
        end else if ((remaining_q >= COIN_20) && (cnt_20 != 4'd0)) begin
            pick     = 1'b1;
            pick_sel = SEL_20;
            pick_val = COIN_20;
        end else if ((remaining_q >= COIN_10) && (cnt_10 != 4'd0)) begin
            pick     = 1'b1;
            pick_sel = SEL_10;
            pick_val = COIN_10;
        end
    end

    always_comb begin
        dec_10 = (state_q == StSelect) && pick && (pick_sel == SEL_10);
        dec_20 = (state_q == StSelect) && pick && (pick_sel == SEL_20);
        dec_50 = (state_q == StSelect) && pick && (pick_sel == SEL_50);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= 5'd0;
            timer_q     <= 4'd0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            shortfall   <= 5'd0;
            eject_10    <= 1'b0;
            eject_20    <= 1'b0;
            eject_50    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        remaining_q <= req_amount;
                        shortfall   <= 5'd0;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StSelect;
                    end
                end
                StSelect: begin
                    if (pick) begin
                        remaining_q <= remaining_q - pick_val;
                        eject_10    <= (pick_sel == SEL_10);
                        eject_20    <= (pick_sel == SEL_20);
                        eject_50    <= (pick_sel == SEL_50);
                        timer_q     <= PulseLoad;
                        state_q     <= StPulse;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= remaining_q;
                        state_q   <= StDone;
                    end
                end
                StPulse: begin
                    if (timer_q == 4'd0) begin
                        eject_10 <= 1'b0;
                        eject_20 <= 1'b0;
                        eject_50 <= 1'b0;
                        timer_q  <= GapLoad;
                        state_q  <= StGap;
                    end else begin
                        timer_q <= timer_q - 4'd1;
                    end
                end
                StGap: begin
                    if (timer_q == 4'd0) begin
                        state_q <= StSelect;
                    end else begin
                        timer_q <= timer_q - 4'd1;
                    end
                end
                StDone: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    eject_10  <= 1'b0;
                    eject_20  <= 1'b0;
                    eject_50  <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    coin_tube_counter #(
        .TubeMax (TUBE_MAX),
        .TubeInit(TUBE_INIT)
    ) u_tube_10 (
        .clk_i  (clk),
        .reset_i(reset),
        .inc_i  (refill_10),
        .dec_i  (dec_10),
        .cnt_o  (cnt_10)
    );

    coin_tube_counter #(
        .TubeMax (TUBE_MAX),
        .TubeInit(TUBE_INIT)
    ) u_tube_20 (
        .clk_i  (clk),
        .reset_i(reset),
        .inc_i  (refill_20),
        .dec_i  (dec_20),
        .cnt_o  (cnt_20)
    );

    coin_tube_counter #(
        .TubeMax (TUBE_MAX),
        .TubeInit(TUBE_INIT)
    ) u_tube_50 (
        .clk_i  (clk),
        .reset_i(reset),
        .inc_i  (refill_50),
        .dec_i  (dec_50),
        .cnt_o  (cnt_50)
    );

endmodule

// File: tb/tb_change_return_controller.sv
// Directed bench for change_return_controller with default parameters (3/2/15/8).
module tb_change_return_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [4:0] req_amount = 5'd0;
    logic       req_ready;
    logic       eject_10, eject_20, eject_50;
    logic       busy, done;
    logic [4:0] shortfall;
    logic       refill_10 = 1'b0, refill_20 = 1'b0, refill_50 = 1'b0;
    logic [3:0] cnt_10, cnt_20, cnt_50;

    int errors = 0;
    int checks = 0;

    logic [2:0] ej_tr   [0:39];
    logic       done_tr [0:39];
    logic       rdy_tr  [0:39];
    logic       busy_tr [0:39];
    logic [4:0] sf_tr   [0:39];

    change_return_controller dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_amount(req_amount),
        .req_ready (req_ready),
        .eject_10  (eject_10),
        .eject_20  (eject_20),
        .eject_50  (eject_50),
        .busy      (busy),
        .done      (done),
        .shortfall (shortfall),
        .refill_10 (refill_10),
        .refill_20 (refill_20),
        .refill_50 (refill_50),
        .cnt_10    (cnt_10),
        .cnt_20    (cnt_20),
        .cnt_50    (cnt_50)
    );

    always #5 clk = ~clk;

    // Issue a request at the current negedge and record outputs at the next ncyc negedges.
    // With hold set, req_valid stays high with alt_amt until done is seen.
    task automatic capture(input logic [4:0] amt, input int ncyc, input logic hold,
                           input logic [4:0] alt_amt);
        req_valid  = 1'b1;
        req_amount = amt;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (hold) req_amount = alt_amt;
            else req_valid = 1'b0;
            ej_tr[k]   = {eject_50, eject_20, eject_10};
            done_tr[k] = done;
            rdy_tr[k]  = req_ready;
            busy_tr[k] = busy;
            sf_tr[k]   = shortfall;
            if (hold && done) req_valid = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, busy, done, eject_50, eject_20, eject_10} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/busy/done/ej=%b want 100000",
                     {req_ready, busy, done, eject_50, eject_20, eject_10});
        end
        checks++;
        if ({shortfall, cnt_50, cnt_20, cnt_10} !== {5'd0, 4'd8, 4'd8, 4'd8}) begin
            errors++;
            $display("FAIL reset_state: got sf=%0d cnt50=%0d cnt20=%0d cnt10=%0d want 0 8 8 8",
                     shortfall, cnt_50, cnt_20, cnt_10);
        end
    endtask

    task automatic test_pay_40();
        logic [2:0] exp;
        capture(5'd4, 15, 1'b0, 5'd0);
        for (int k = 1; k <= 15; k++) begin
            exp = ((k >= 2 && k <= 4) || (k >= 8 && k <= 10)) ? 3'b010 : 3'b000;
            checks++;
            if (ej_tr[k] !== exp) begin
                errors++;
                $display("FAIL pay40_eject[%0d]: got %b want %b", k, ej_tr[k], exp);
            end
            checks++;
            if (done_tr[k] !== (k == 14)) begin
                errors++;
                $display("FAIL pay40_done[%0d]: got %b want %b", k, done_tr[k], k == 14);
            end
            checks++;
            if (busy_tr[k] !== (k <= 14) || rdy_tr[k] !== (k == 15)) begin
                errors++;
                $display("FAIL pay40_busy_ready[%0d]: got %b%b want %b%b", k, busy_tr[k],
                         rdy_tr[k], k <= 14, k == 15);
            end
        end
        checks++;
        if (sf_tr[14] !== 5'd0) begin
            errors++;
            $display("FAIL pay40_shortfall: got %0d want 0", sf_tr[14]);
        end
        checks++;
        if ({cnt_50, cnt_20, cnt_10} !== {4'd8, 4'd6, 4'd8}) begin
            errors++;
            $display("FAIL pay40_counts: got %0d %0d %0d want 8 6 8", cnt_50, cnt_20, cnt_10);
        end
    endtask

    task automatic test_pay_80();
        logic [2:0] exp;
        capture(5'd8, 21, 1'b0, 5'd0);
        for (int k = 1; k <= 21; k++) begin
            exp = (k >= 2 && k <= 4) ? 3'b100 :
                  (k >= 8 && k <= 10) ? 3'b010 :
                  (k >= 14 && k <= 16) ? 3'b001 : 3'b000;
            checks++;
            if (ej_tr[k] !== exp || done_tr[k] !== (k == 20)) begin
                errors++;
                $display("FAIL pay80_trace[%0d]: got ej=%b done=%b want ej=%b done=%b", k,
                         ej_tr[k], done_tr[k], exp, k == 20);
            end
        end
        checks++;
        if (sf_tr[20] !== 5'd0) begin
            errors++;
            $display("FAIL pay80_shortfall: got %0d want 0", sf_tr[20]);
        end
        checks++;
        if ({cnt_50, cnt_20, cnt_10} !== {4'd7, 4'd5, 4'd7}) begin
            errors++;
            $display("FAIL pay80_counts: got %0d %0d %0d want 7 5 7", cnt_50, cnt_20, cnt_10);
        end
    endtask

    task automatic test_shortfall();
        for (int i = 0; i < 7; i++) begin
            capture(5'd1, 9, 1'b0, 5'd0);
            checks++;
            if (ej_tr[2] !== 3'b001 || done_tr[8] !== 1'b1) begin
                errors++;
                $display("FAIL drain10[%0d]: got ej=%b done=%b want 001 1", i, ej_tr[2],
                         done_tr[8]);
            end
        end
        checks++;
        if (cnt_10 !== 4'd0) begin
            errors++;
            $display("FAIL drain10_count: got %0d want 0", cnt_10);
        end
        capture(5'd6, 10, 1'b0, 5'd0);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (ej_tr[k] !== ((k >= 2 && k <= 4) ? 3'b100 : 3'b000) ||
                done_tr[k] !== (k == 8)) begin
                errors++;
                $display("FAIL short6_trace[%0d]: got ej=%b done=%b", k, ej_tr[k], done_tr[k]);
            end
        end
        checks++;
        if (sf_tr[8] !== 5'd1 || sf_tr[10] !== 5'd1) begin
            errors++;
            $display("FAIL short6_shortfall: got %0d/%0d want 1/1", sf_tr[8], sf_tr[10]);
        end
        checks++;
        if ({cnt_50, cnt_20, cnt_10} !== {4'd6, 4'd5, 4'd0}) begin
            errors++;
            $display("FAIL short6_counts: got %0d %0d %0d want 6 5 0", cnt_50, cnt_20, cnt_10);
        end
    endtask

    task automatic test_busy_ignore();
        capture(5'd2, 10, 1'b1, 5'd5);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (ej_tr[k] !== ((k >= 2 && k <= 4) ? 3'b010 : 3'b000) ||
                rdy_tr[k] !== (k >= 9)) begin
                errors++;
                $display("FAIL busy_ignore[%0d]: got ej=%b rdy=%b want ej=%b rdy=%b", k,
                         ej_tr[k], rdy_tr[k], (k >= 2 && k <= 4) ? 3'b010 : 3'b000, k >= 9);
            end
        end
        checks++;
        if ({cnt_50, cnt_20} !== {4'd6, 4'd4}) begin
            errors++;
            $display("FAIL busy_ignore_counts: got %0d %0d want 6 4", cnt_50, cnt_20);
        end
    endtask

    task automatic test_refill();
        logic seen;
        do_reset();
        req_valid  = 1'b1;
        req_amount = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        refill_50 = 1'b1;    // state is SELECT now, choosing 50c
        @(negedge clk);
        refill_50 = 1'b0;
        checks++;
        if (cnt_50 !== 4'd8 || eject_50 !== 1'b1) begin
            errors++;
            $display("FAIL refill_collide: got cnt50=%0d ej50=%b want 8 1", cnt_50, eject_50);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL refill_payout_done: got no done within 20 cycles, want done");
        end
        @(negedge clk);
        refill_10 = 1'b1;
        repeat (7) @(negedge clk);
        checks++;
        if (cnt_10 !== 4'd15) begin
            errors++;
            $display("FAIL refill_to_max: got %0d want 15", cnt_10);
        end
        @(negedge clk);
        refill_10 = 1'b0;
        checks++;
        if (cnt_10 !== 4'd15) begin
            errors++;
            $display("FAIL refill_saturate: got %0d want 15", cnt_10);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        capture(5'd8, 9, 1'b0, 5'd0);
        checks++;
        if (ej_tr[9] !== 3'b010) begin
            errors++;
            $display("FAIL midreset_pre: got ej=%b want 010", ej_tr[9]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({eject_50, eject_20, eject_10, busy, done, req_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL midreset_outputs: got ej/busy/done/rdy=%b want 000001",
                     {eject_50, eject_20, eject_10, busy, done, req_ready});
        end
        checks++;
        if ({cnt_50, cnt_20, cnt_10} !== {4'd8, 4'd8, 4'd8}) begin
            errors++;
            $display("FAIL midreset_counts: got %0d %0d %0d want 8 8 8", cnt_50, cnt_20, cnt_10);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if ({done, busy, eject_50, eject_20, eject_10} !== 5'b00000) begin
                errors++;
                $display("FAIL midreset_quiet[%0d]: got done/busy/ej=%b want 00000", k,
                         {done, busy, eject_50, eject_20, eject_10});
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pay_40();
        test_pay_80();
        test_shortfall();
        test_busy_ignore();
        test_refill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
